// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with registered read data, occupancy decodes and sticky error flags
module fifo_param #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wt_en,
  input  logic          rd_en,
  input  logic [DW-1:0] din,
  input  logic          err_clr,
  output logic [DW-1:0] dout,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wt_p, rd_p;
  logic          wr_acc, rd_acc;
  always_comb begin
    full         = count == CW'(DEPTH);
    empty        = count == '0;
    almost_full  = count >= CW'(AF_TH);
    almost_empty = count <= CW'(AE_TH);
    wr_acc       = wt_en & ~full;
    rd_acc       = rd_en & ~empty;
  end
  // Storage has no reset; reset only discards it through the pointers.
  always_ff @(posedge clk)
    if (!rst && wr_acc) mem[wt_p] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wt_p      <= '0;
      rd_p      <= '0;
      count     <= '0;
      dout      <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wt_p <= wt_p + 1'b1;
      if (rd_acc) begin
        dout <= mem[rd_p];
        rd_p <= rd_p + 1'b1;
      end
      rd_valid  <= rd_acc;
      count     <= count + CW'(wr_acc) - CW'(rd_acc);
      overflow  <= (wt_en & full) | (overflow & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed stimulus against a queue-based reference model of fifo_param
module tb_fifo_param;
  logic       clk = 0, rst = 1, wt_en = 0, rd_en = 0, err_clr = 0;
  logic [7:0] din = 0, dout;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0;
  bit chk_on = 0;
  logic [7:0] q[$];
  logic [7:0] m_dout = 0;
  bit m_rv = 0, m_ov = 0, m_un = 0;

  fifo_param #(.DW(8), .DEPTH(16), .AF_TH(14), .AE_TH(2)) dut (
    .clk(clk), .rst(rst), .wt_en(wt_en), .rd_en(rd_en), .din(din), .err_clr(err_clr),
    .dout(dout), .rd_valid(rd_valid), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", n, $time, a, e);
    end
  endtask

  // Reference: a queue of stored words; pop happens before push so full/empty use pre-edge state.
  initial forever begin
    bit f, e;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_dout = 0; m_rv = 0; m_ov = 0; m_un = 0;
    end else begin
      f = q.size() == 16;
      e = q.size() == 0;
      m_ov = (wt_en && f) || (m_ov && !err_clr);
      m_un = (rd_en && e) || (m_un && !err_clr);
      m_rv = rd_en && !e;
      if (m_rv) m_dout = q.pop_front();
      if (wt_en && !f) q.push_back(din);
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("count", count, q.size());
      chk("full", full, q.size() == 16);
      chk("empty", empty, q.size() == 0);
      chk("almost_full", almost_full, q.size() >= 14);
      chk("almost_empty", almost_empty, q.size() <= 2);
      chk("rd_valid", rd_valid, m_rv);
      chk("dout", dout, m_dout);
      chk("overflow", overflow, m_ov);
      chk("underflow", underflow, m_un);
    end
  end

  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    wt_en = w; rd_en = r; din = d; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0);
    rst = 0;
    chk_on = 1;
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst full", full, 0);
    chk("rst almost_full", almost_full, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0);
      if (i == 12) chk("af at 13", almost_full, 0);
      if (i == 13) chk("af at 14", almost_full, 1);
    end
    chk("fill count", count, 16);
    chk("fill full", full, 1);
    step(1, 0, 8'hAA, 0);
    chk("ovf set", overflow, 1);
    chk("ovf count", count, 16);
    step(0, 0, 0, 1);
    chk("ovf clr", overflow, 0);
    step(1, 0, 0, 0);
    step(1, 0, 8'hBB, 1);
    chk("ovf set wins", overflow, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0);
      chk("drain rv", rd_valid, 1);
      chk("drain dout", dout, i);
    end
    step(0, 1, 0, 0);
    chk("unf set", underflow, 1);
    chk("unf dout hold", dout, 8'h0F);
    chk("unf rv", rd_valid, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 8'(8'h20 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 8'(8'h30 + i), 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0);
      chk("wrap dout", dout, 8'h30 + i);
    end
    chk("wrap count", count, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h50 + i), 0);
    chk("both count", count, 5);
    chk("both dout", dout, 8'h5E);
    for (int i = 0; i < 11; i++) step(1, 0, 8'(8'h70 + i), 0);
    chk("refill full", full, 1);
    step(1, 1, 8'hCC, 0);
    chk("full both count", count, 15);
    chk("full both ovf", overflow, 1);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
    chk("drain empty", empty, 1);
    step(1, 1, 8'hDD, 0);
    chk("empty both count", count, 1);
    chk("empty both unf", underflow, 1);
    chk("empty both rv", rd_valid, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h90 + i), 0);
    chk("pre-rst count", count, 7);
    rst = 1;
    step(1, 0, 8'hEE, 0);
    rst = 0;
    chk("mid rst count", count, 0);
    chk("mid rst empty", empty, 1);
    chk("mid rst rv", rd_valid, 0);
    chk("mid rst ovf", overflow, 0);
    chk("mid rst unf", underflow, 0);
    step(1, 0, 8'h11, 0);
    step(0, 1, 0, 0);
    chk("post rst dout", dout, 8'h11);
    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
